// File: rtl/uart_wr_arbiter_pkg.sv
// uart_wr_arbiter_pkg
// Shared definitions for the UART register-write arbiter: UART register
// numbers, the divisor value programmed at init, the FSM state encoding and
// the per-port eligibility rule used by the top level.
package uart_wr_arbiter_pkg;

    // UART register map
    localparam logic [2:0]  DATA_REG_NUM     = 3'd0;
    localparam logic [2:0]  DIV_REG_NUM      = 3'd3;

    // Baud divisor written once after reset
    localparam logic [31:0] DIV_INIT_DEFAULT = 32'h0000_007F;

    // Cycles that data writes stay blocked after a data write
    localparam logic [2:0]  HOLDOFF_DEFAULT  = 3'd2;

    // FSM state encoding
    localparam logic [1:0]  ST_INIT  = 2'd0;
    localparam logic [1:0]  ST_IDLE  = 2'd1;
    localparam logic [1:0]  ST_WRITE = 2'd2;

    // A data-register write must wait for an idle transmitter and an expired
    // holdoff window; any other register goes straight through.
    function automatic logic is_eligible(
        input logic       req,
        input logic [2:0] reg_num,
        input logic [2:0] data_reg,
        input logic       tx_busy,
        input logic       holdoff_zero
    );
        return req && ((reg_num != data_reg) || (!tx_busy && holdoff_zero));
    endfunction

endpackage

// File: rtl/uart_wr_arbiter_rr_arb2.sv
// uart_wr_arbiter_rr_arb2
// Two-input round-robin arbiter. The grant is combinational from the
// eligible vector and the internal pointer; the pointer moves to the port
// that did not win whenever a grant is taken under the update strobe.
//   clk       system clock
//   rst_n     asynchronous active-low reset (pointer -> port 0)
//   eligible  per-port eligibility
//   update    strobe: consume the current grant and advance the pointer
//   grant     one-hot grant, 2'b00 when nothing is eligible
module uart_wr_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] eligible,
    input  logic       update,
    output logic [1:0] grant
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
        rr_d = rr_q;
        // Winner port 0 -> pointer to port 1, winner port 1 -> pointer to 0
        if (update && (grant != 2'b00)) begin
            rr_d = grant[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/uart_wr_arbiter.sv
// uart_wr_arbiter
// Shares the single UART register-write port between the CPU store path
// (port 0) and the debug/boot loader (port 1). After reset it writes the
// baud divisor once, then grants requests round-robin, one write every two
// cycles, holding back TX data writes while the UART is busy or inside the
// holdoff window that follows a data write. All outputs are registered.
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/reg0/wd0, ack0   port 0 request, register, data, one-cycle ack
//   req1/reg1/wd1, ack1   port 1 request, register, data, one-cycle ack
//   tx_busy               UART transmitter busy
//   uart_we/reg_num/wd    write port towards the UART
//   init_done             high once the divisor write has completed
module uart_wr_arbiter
    import uart_wr_arbiter_pkg::*;
#(
    parameter logic [31:0] DIV_INIT = DIV_INIT_DEFAULT,
    parameter logic [2:0]  DIV_REG  = DIV_REG_NUM,
    parameter logic [2:0]  DATA_REG = DATA_REG_NUM,
    parameter logic [2:0]  HOLDOFF  = HOLDOFF_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [2:0]  reg0,
    input  logic [31:0] wd0,
    output logic        ack0,
    input  logic        req1,
    input  logic [2:0]  reg1,
    input  logic [31:0] wd1,
    output logic        ack1,
    input  logic        tx_busy,
    output logic        uart_we,
    output logic [2:0]  uart_reg_num,
    output logic [31:0] uart_wd,
    output logic        init_done
);

    logic [1:0]  state_q, state_d;
    logic [2:0]  holdoff_q, holdoff_d;
    logic        we_q, we_d;
    logic [2:0]  reg_num_q, reg_num_d;
    logic [31:0] wd_q, wd_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        init_done_q, init_done_d;

    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic        arb_update;

    assign eligible[0] = is_eligible(req0, reg0, DATA_REG, tx_busy, holdoff_q == 3'd0);
    assign eligible[1] = is_eligible(req1, reg1, DATA_REG, tx_busy, holdoff_q == 3'd0);
    assign arb_update  = (state_q == ST_IDLE);

    uart_wr_arbiter_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .update   (arb_update),
        .grant    (grant)
    );

    // INIT loads the divisor write and passes through WRITE like any other
    // write, so the divisor write also occupies the port for exactly one
    // cycle and the two-cycle write rhythm holds from the start.
    always_comb begin
        state_d     = state_q;
        we_d        = 1'b0;
        reg_num_d   = reg_num_q;
        wd_d        = wd_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        init_done_d = init_done_q;
        holdoff_d   = (holdoff_q != 3'd0) ? holdoff_q - 3'd1 : 3'd0;

        case (state_q)
            ST_INIT: begin
                we_d      = 1'b1;
                reg_num_d = DIV_REG;
                wd_d      = DIV_INIT;
                state_d   = ST_WRITE;
            end
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    we_d    = 1'b1;
                    state_d = ST_WRITE;
                    if (grant[0]) begin
                        ack0_d    = 1'b1;
                        reg_num_d = reg0;
                        wd_d      = wd0;
                    end else begin
                        ack1_d    = 1'b1;
                        reg_num_d = reg1;
                        wd_d      = wd1;
                    end
                end
            end
            ST_WRITE: begin
                state_d     = ST_IDLE;
                init_done_d = 1'b1;
                // Only requester data writes arm the holdoff, not the
                // divisor write issued from INIT.
                if ((ack0_q || ack1_q) && (reg_num_q == DATA_REG)) begin
                    holdoff_d = HOLDOFF;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            holdoff_q   <= 3'd0;
            we_q        <= 1'b0;
            reg_num_q   <= 3'd0;
            wd_q        <= 32'd0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            holdoff_q   <= holdoff_d;
            we_q        <= we_d;
            reg_num_q   <= reg_num_d;
            wd_q        <= wd_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            init_done_q <= init_done_d;
        end
    end

    assign uart_we      = we_q;
    assign uart_reg_num = reg_num_q;
    assign uart_wd      = wd_q;
    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign init_done    = init_done_q;

endmodule

// File: doc/uart_wr_arbiter.md
Name: uart_wr_arbiter

Overview:
Sequences and shares the single UART register-write port (we / reg_num / wd) between two requesters: port 0 (CPU store path) and port 1 (debug/boot loader).
- After reset, autonomously programs the baud divisor register before accepting any request.
- Arbitrates round-robin between the two ports.
- Blocks writes to the TX data register while the UART reports busy.
- Sits between the core's MMIO decode and the uart instance.

Parameters:
DIV_INIT, 32'h0000007F, divisor value written at init
DIV_REG, 3, register number of the divisor register
DATA_REG, 0, register number of the TX data register
HOLDOFF, 2, cycles after a data write during which tx_busy is ignored and data writes stay blocked (range 1..7)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 write request, held until ack0
reg0  in  3  port 0 target register number
wd0  in  32  port 0 write data
ack0  out  1  one-cycle pulse, port 0 write issued
req1  in  1  port 1 write request, held until ack1
reg1  in  3  port 1 target register number
wd1  in  32  port 1 write data
ack1  out  1  one-cycle pulse, port 1 write issued
tx_busy  in  1  UART transmitter busy
uart_we  out  1  to uart we
uart_reg_num  out  3  to uart reg_num
uart_wd  out  32  to uart wd
init_done  out  1  high once the divisor write is complete

Behaviour:
- Reset (async on rst_n low): state=INIT; all outputs 0; rr pointer=0; holdoff counter=0. Asserting reset mid-write drops uart_we and ack immediately; the request is not considered issued.
- All outputs are registered; nothing is combinational from inputs to outputs.
- FSM states:
  - INIT: first cycle after reset release. Drive uart_we=1, uart_reg_num=DIV_REG, uart_wd=DIV_INIT for exactly one cycle, then go to IDLE. init_done=1 from the IDLE entry onward. No acks in INIT.
  - IDLE: arbitrate among eligible ports. Port N is eligible iff reqN=1 and (regN!=DATA_REG or (tx_busy=0 and holdoff==0)).
    - Winner is loaded into the output regs and the FSM goes to WRITE.
    - With no eligible port, outputs stay with uart_we=0; reg_num/wd keep their last values.
  - WRITE: uart_we=1 and ackN=1 for the winner, in the same cycle. Always return to IDLE next cycle; no arbitration in WRITE.
- Throughput: at most one write per 2 cycles.
- Latency: a request that is eligible in IDLE produces uart_we and ack on the next cycle.
- Round-robin:
  - Both ports eligible: winner is the port indicated by rr. After a grant, rr points to the other port.
  - Exactly one port eligible: it wins and rr is updated the same way.
  - A blocked data write does not block the other port's non-data write; the non-data write may bypass it.
- Holdoff:
  - On issuing a write with reg==DATA_REG, the counter loads HOLDOFF in the WRITE cycle.
  - The counter decrements each cycle while nonzero, saturating at 0.
  - This covers the UART's delay in raising tx_busy.
- Requesters must hold reqN/regN/wdN stable until ack and drop req in the cycle after ack. A req still high in IDLE after ack is treated as a new request.
- reg values 1..7 other than DATA_REG pass through unchecked.

Decomposition:
- Shared package: UART register numbers (DATA_REG=0, DIV_REG=3), FSM state encoding (INIT, IDLE, WRITE), DIV_INIT default.
- One natural sub-module: rr_arb2 (2-input round-robin arbiter: eligible[1:0], update strobe -> one-hot grant).
- Holdoff counter and FSM stay in the top module.

Test Plan:
- Reset release, no requests -> cycle 1: uart_we=1, reg=3, wd=0x7F. Cycle 2: uart_we=0, init_done=1.
- req0 reg=0 wd=0x41, tx_busy=0 -> next cycle uart_we=1, reg=0, wd=0x41, ack0=1. A second req0 data write issued immediately after is delayed HOLDOFF cycles even with tx_busy=0.
- req0 and req1 held continuously with reg=2 -> grants alternate 0,1,0,1 on every second cycle; each ack is a single-cycle pulse.
- tx_busy=1, req0 reg=0 wd=0x55, req1 reg=3 wd=0x10 -> port 1 issued first (reg=3, wd=0x10). The port 0 write issues only one cycle after tx_busy falls.
- rst_n pulsed low while in WRITE -> uart_we, ack0 and ack1 go 0 asynchronously; after release the INIT write of 0x7F to reg 3 repeats.
- Write to reg 5 with tx_busy=1 -> issued without stall; holdoff counter stays 0.
